// File: rtl/stack_ctrl.sv
// ============================================================================
// Module   : stack_ctrl
// Brief    : Multi-channel hardware stack pointer controller issuing
//            registered memory address strobes for push/pop/peek commands.
//            Optional sticky error flag enabled by STACK_CTRL_STICKY_ERR_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module stack_ctrl #(
  parameter int                  CHANNELS = 16,
  parameter int                  DEPTH_W  = 9,
  parameter int                  REGION_W = 7,
  parameter logic [REGION_W-1:0] BASE_HI  = 7'h23
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [3:0]                  sel,
  input  logic                        cmd_valid,
  input  logic                        push,
  input  logic                        pop,
  input  logic                        peek,
  input  logic                        read_done,
  input  logic                        clr,
  output logic [REGION_W+DEPTH_W-1:0] addr,
  output logic                        addr_valid,
  output logic                        addr_wr,
  output logic                        busy,
  output logic                        overflow,
  output logic                        underflow,
`ifdef STACK_CTRL_STICKY_ERR_EN
  input  logic                        err_clr,
  output logic                        err_sticky,
`endif
  output logic [DEPTH_W-1:0]          level
);

  localparam int                 NCH      = 16;
  localparam logic [4:0]         C_CH_LIM = 5'(CHANNELS);
  localparam logic [DEPTH_W-1:0] C_ONE    = {{(DEPTH_W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    S_IDLE     = 1'b0,
    S_POP_WAIT = 1'b1
  } state_t;

  state_t                        state_q;
  logic [DEPTH_W-1:0]            ptr_q [NCH];
  logic [3:0]                    last_q;
  logic [REGION_W+DEPTH_W-1:0]   addr_q;
  logic                          addr_valid_q;
  logic                          addr_wr_q;
  logic                          overflow_q;
  logic                          underflow_q;

  logic                          w_sel_ok;
  logic                          w_cmd;
  logic [DEPTH_W-1:0]            w_cur;
  logic [DEPTH_W-1:0]            w_inc;
  logic [REGION_W-1:0]           w_region;
  logic                          w_full;
  logic                          w_empty;

  always_comb begin
    w_sel_ok = ({1'b0, sel} < C_CH_LIM);
    w_cmd    = cmd_valid && w_sel_ok && (push || pop || peek);
    w_cur    = ptr_q[sel];
    w_inc    = w_cur + C_ONE;
    w_region = BASE_HI - REGION_W'(sel);
    w_full   = &w_cur;
    w_empty  = (w_cur == '0);
  end

  // Strobes and error pulses default low every cycle; only an accepted
  // command in IDLE raises them for exactly one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      last_q       <= '0;
      addr_q       <= '0;
      addr_valid_q <= 1'b0;
      addr_wr_q    <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        ptr_q[i] <= '0;
      end
    end else begin
      addr_valid_q <= 1'b0;
      addr_wr_q    <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (clr) begin
            ptr_q[last_q] <= '0;
          end else if (w_cmd) begin
            last_q <= sel;
            if (push) begin
              if (w_full) begin
                overflow_q <= 1'b1;
              end else begin
                ptr_q[sel]   <= w_inc;
                addr_q       <= {w_region, w_inc};
                addr_valid_q <= 1'b1;
                addr_wr_q    <= 1'b1;
              end
            end else if (pop) begin
              if (w_empty) begin
                underflow_q <= 1'b1;
              end else begin
                addr_q       <= {w_region, w_cur};
                addr_valid_q <= 1'b1;
                state_q      <= S_POP_WAIT;
              end
            end else begin
              if (w_empty) begin
                underflow_q <= 1'b1;
              end else begin
                addr_q       <= {w_region, w_cur};
                addr_valid_q <= 1'b1;
              end
            end
          end
        end
        S_POP_WAIT: begin
          // The popped channel is always the last-selected one.
          if (clr) begin
            ptr_q[last_q] <= '0;
            state_q       <= S_IDLE;
          end else if (read_done) begin
            ptr_q[last_q] <= ptr_q[last_q] - C_ONE;
            state_q       <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef STACK_CTRL_STICKY_ERR_EN
  logic err_sticky_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky_q <= 1'b0;
    end else if (overflow_q || underflow_q) begin
      err_sticky_q <= 1'b1;
    end else if (err_clr) begin
      err_sticky_q <= 1'b0;
    end
  end

  assign err_sticky = err_sticky_q;
`endif

  assign addr       = addr_q;
  assign addr_valid = addr_valid_q;
  assign addr_wr    = addr_wr_q;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;
  assign busy       = (state_q == S_POP_WAIT);
  assign level      = ptr_q[last_q];

endmodule

`default_nettype wire

// File: doc/stack_ctrl.md
STACK_CTRL -- requirements
Module: stack_ctrl

Interface
REQ-001 SHALL have parameter CHANNELS, default 16, number of independent stacks (1..16).
REQ-002 SHALL have parameter DEPTH_W, default 9, per-stack pointer width; capacity 2^DEPTH_W-1 entries.
REQ-003 SHALL have parameter REGION_W, default 7, width of memory region field.
REQ-004 SHALL have parameter BASE_HI, default 7'h23, region of channel 0; channel k uses region BASE_HI-k.
REQ-005 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port sel  input  4  channel index of command.
REQ-008 SHALL have port cmd_valid  input  1  command strobe qualifying push/pop/peek.
REQ-009 SHALL have ports push, pop, peek  input  1 each  command type; priority push > pop > peek.
REQ-010 SHALL have port read_done  input  1  memory has consumed pop data.
REQ-011 SHALL have port clr  input  1  zero pointer of last-selected channel.
REQ-012 SHALL have port addr  output  REGION_W+DEPTH_W  memory address {BASE_HI-ch, ptr}.
REQ-013 SHALL have ports addr_valid, addr_wr  output  1 each  address strobe; addr_wr=1 for push.
REQ-014 SHALL have port busy  output  1  high in POP_WAIT; commands ignored.
REQ-015 SHALL have ports overflow, underflow  output  1 each  single-cycle error pulses.
REQ-016 SHALL have port level  output  DEPTH_W  pointer of last-selected channel.

Function
REQ-017 SHALL use states IDLE and POP_WAIT; commands accepted only in IDLE with cmd_valid=1.
REQ-018 Push accepted: ptr<max -> ptr+1, next cycle addr={region,ptr+1}, addr_valid=1, addr_wr=1; ptr==2^DEPTH_W-1 -> overflow=1 next cycle, ptr unchanged, no strobe.
REQ-019 Pop accepted: ptr>0 -> next cycle addr={region,ptr}, addr_valid=1, addr_wr=0, enter POP_WAIT; ptr==0 -> underflow=1 next cycle, stay IDLE, no strobe.
REQ-020 In POP_WAIT, read_done=1 SHALL decrement ptr of the popped channel and return to IDLE next cycle.
REQ-021 Peek SHALL issue addr={region,ptr}, addr_valid=1, addr_wr=0 next cycle without state change or pointer change; ptr==0 -> underflow pulse instead.
REQ-022 All outputs except level SHALL be registered: one-cycle latency from accepted command.
REQ-023 sel>=CHANNELS SHALL be ignored (no strobe, no error, no state change).
REQ-024 clr SHALL have priority over any command in same cycle; command dropped, ptr zeroed.
REQ-025 clr in POP_WAIT SHALL zero ptr and return to IDLE; a later read_done SHALL be ignored.
REQ-026 Pointers SHALL never wrap; arithmetic saturates via REQ-018/019.

Reset
REQ-027 rst_n=0 SHALL immediately zero all pointers, last-selected channel, addr, addr_valid, addr_wr, overflow, underflow, and force IDLE (busy=0), independent of clk.
REQ-028 Reset during POP_WAIT SHALL discard the pending decrement.

Configuration
REQ-029 With STACK_CTRL_STICKY_ERR_EN defined, SHALL add input err_clr and output err_sticky: set by any overflow/underflow pulse, cleared by err_clr (set wins if same cycle), reset 0.
REQ-030 Without STACK_CTRL_STICKY_ERR_EN, err_clr and err_sticky SHALL not exist; pulses only.

Verification
REQ-031 Reset, push ch0 three times -> addr 0x4601, 0x4602, 0x4603 with addr_wr=1, level=3.
REQ-032 Push ch15 once, pop ch15 -> addr 0x2801 addr_wr=0, busy=1 until read_done, then level=0.
REQ-033 Pop ch3 when empty -> underflow=1 one cycle, no addr_valid, busy=0.
REQ-034 Fill ch2 to 511 then push -> overflow=1, level stays 511, no addr_valid.
REQ-035 Push ch1 twice, pop ch1, clr before read_done -> IDLE next cycle, level=0, late read_done ignored.
REQ-036 With STACK_CTRL_STICKY_ERR_EN: underflow -> err_sticky=1 held; err_clr -> 0.
